// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digits(input int n, input int w);
    return n / w;
  endfunction

  function automatic int cnt_width(input int n, input int w);
    int c;
    c = $clog2(n / w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational W-bit ripple-borrow subtractor cell: diff = x - y - bi, LSB to MSB.
module sub_digit #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  logic br_s;

  // Full-subtractor chain; br_s carries the borrow from bit i into bit i+1.
  always_comb begin
    diff = {W{1'b0}};
    br_s = bi;
    for (int i = 0; i < W; i++) begin
      diff[i] = x[i] ^ y[i] ^ br_s;
      br_s    = (~x[i] & y[i]) | (~x[i] & br_s) | (y[i] & br_s);
    end
    bo = br_s;
  end

endmodule

// File: rtl/digit_serial_subtractor.sv
// N-bit unsigned subtractor d = a - b - bin, W bits per clock, LSB digit first,
// with valid/ready handshakes on both the operand and the result side.
module digit_serial_subtractor
  import adder_pkg::*;
#(
  parameter int N = 256,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int ND = digits(N, W);
  localparam int CW = cnt_width(N, W);
  localparam logic [CW-1:0] LAST_CNT = CW'(ND - 1);

  if ((N % W) != 0) begin : g_bad_width
    $error("digit_serial_subtractor: N must be a multiple of W");
  end

  state_t        state_r;
  state_t        state_nx_s;
  logic [N-1:0]  a_sh_r;
  logic [N-1:0]  b_sh_r;
  logic [N-1:0]  d_sh_r;
  logic [N-1:0]  d_r;
  logic          brw_r;
  logic          bout_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  cell_diff_s;
  logic          cell_bo_s;
  logic [N-1:0]  diff_ext_s;
  logic [N-1:0]  d_nx_s;
  logic          last_s;

  sub_digit #(.W(W)) u_cell (
    .x    (a_sh_r[W-1:0]),
    .y    (b_sh_r[W-1:0]),
    .bi   (brw_r),
    .diff (cell_diff_s),
    .bo   (cell_bo_s)
  );

  // New digit enters at the MSB end so the last digit lands the full result in place.
  assign diff_ext_s = N'(cell_diff_s);
  assign d_nx_s     = (d_sh_r >> W) | (diff_ext_s << (N - W));
  assign last_s     = (cnt_r == LAST_CNT);

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign d         = d_r;
  assign bout      = bout_r;

  // Next-state decode for the IDLE -> RUN -> DONE handshake sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shifters, borrow, digit counter and the held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {N{1'b0}};
      b_sh_r <= {N{1'b0}};
      d_sh_r <= {N{1'b0}};
      d_r    <= {N{1'b0}};
      brw_r  <= 1'b0;
      bout_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            d_sh_r <= {N{1'b0}};
            brw_r  <= bin;
            cnt_r  <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> W;
          b_sh_r <= b_sh_r >> W;
          d_sh_r <= d_nx_s;
          brw_r  <= cell_bo_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            d_r    <= d_nx_s;
            bout_r <= cell_bo_s;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/digit_serial_subtractor.md
# digit_serial_subtractor

Multi-cycle N-bit unsigned subtractor: computes d = a − b − bin modulo 2^N and the final borrow, W bits per clock, LSB digit first. It is the inverse-operation companion to the ripple-carry full adder in the adder benchmark set. It trades the adder's N-cell ripple chain for one W-bit borrow chain plus a stored borrow. Operands and results move over valid/ready handshakes so it can sit in a streaming datapath.

## Interface
Parameters:
- N, 256, operand/result width in bits.
- W, 8, digit width processed per cycle. N % W must be 0; otherwise elaboration error.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend.
- b  input  N  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- d  output  N  difference.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).

## Operation
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid && in_ready: latch a, b into shift registers, latch bin into the borrow register, clear the digit counter, go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle, the low W bits of a_sh/b_sh plus the borrow register feed the digit cell.
    - The cell's W-bit difference shifts into the MSB end of d_sh. a_sh and b_sh shift right by W.
    - The cell's borrow-out updates the borrow register, and the counter increments.
    - When counter == N/W−1, go to DONE.
  - DONE: out_valid=1, d=d_sh, bout=borrow register.
    - On out_ready, go to IDLE.
- Digit arithmetic is per bit: diff = x^y^bi; bo = (~x&y) | (~x&bi) | (y&bi). It is chained LSB→MSB inside the digit.
- d and bout are registered. Both hold their last value in IDLE until the next accept overwrites d_sh.
- in_valid/a/b/bin are ignored outside IDLE. No back-to-back accept in DONE: in_ready is low until IDLE.
- Reset (any state, including mid-RUN) aborts the operation. It forces IDLE, and the partial result is discarded.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, d=0, bout=0.
  - Counter=0, state=IDLE.
- Accept edge T0. RUN occupies N/W cycles. out_valid rises at edge T0+N/W (32 for defaults).
- Result stays stable while out_valid && !out_ready. There is no timeout.
- Completion edge (out_valid && out_ready): out_valid falls and in_ready rises on the same edge.
  - The next operand set is accepted at the earliest one cycle later.
  - Throughput is one operation per N/W+2 cycles.
- Inputs have no combinational path to outputs. in_ready and out_valid decode from the registered state only.

## Structure
- Shared package `adder_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - Function `digits(N,W)` = N/W and counter width $clog2(N/W) (min 1).
- One sub-module, `sub_digit`: combinational W-bit ripple-borrow cell (ports x[W], y[W], bi, diff[W], bo), built from per-bit full-subtractor equations. The top holds the FSM, counter, shift registers and borrow register.

## Test plan
1. a=5, b=3, bin=0, out_ready=1 → out_valid exactly 32 cycles after accept; d=2, bout=0.
2. a=0, b=1, bin=0 → d=2^256−1 (all ones), bout=1.
3. a=b=0xDEAD…(random), bin=1 → d=all ones, bout=1.
4. Cross-digit borrow: a=2^8, b=1 → d=0xFF, bout=0. Also a=2^255, b=1 → d=2^255−1.
5. Backpressure: out_ready low 10 cycles after out_valid → d/bout stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 → out_valid falls, in_ready rises the same edge.
6. Reset: rst_n asserted at RUN cycle 10 → out_valid=0, in_ready=1, d=0 immediately. After release, a=100, b=58 → d=42, bout=0.

Randomized sweep (N=256 and N=16, W=4) is also required, with d/bout compared against a − b − bin.
